// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: read-after-write hazard detection for the ID stage,
// tracking EXE/MEM destinations and counting forced stall cycles (saturating).
module hazard_scoreboard #(
    parameter int REG_ADDR_LEN = 5,
    parameter bit FORWARD_EN   = 1'b1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_two_src,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    id_wb_en,
    input  logic                    id_mem_r_en,
    input  logic                    flush,
    input  logic                    freeze,
    output logic                    hazard_detected,
    output logic [STALL_CNT_W-1:0]  stall_count
);
    typedef struct packed {
        logic                    valid;
        logic                    wb;
        logic                    load;
        logic [REG_ADDR_LEN-1:0] dest;
    } exe_slot_t;

    // The load flag is only consulted in EXE, so MEM does not keep it.
    typedef struct packed {
        logic                    valid;
        logic                    wb;
        logic [REG_ADDR_LEN-1:0] dest;
    } mem_slot_t;

    exe_slot_t              exe_q, exe_d;
    mem_slot_t              mem_q, mem_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   exe_hit, mem_hit, raw;

    function automatic logic match(input logic v, input logic wb,
                                   input logic [REG_ADDR_LEN-1:0] dest,
                                   input logic [REG_ADDR_LEN-1:0] r);
        return v & wb & (dest == r) & (r != '0);
    endfunction

    // Only the ID sources feed the hazard, keeping it free of a loop through WB_EN squashing.
    always_comb begin
        exe_hit = match(exe_q.valid, exe_q.wb, exe_q.dest, id_src1)
                | (id_two_src & match(exe_q.valid, exe_q.wb, exe_q.dest, id_src2));
        mem_hit = match(mem_q.valid, mem_q.wb, mem_q.dest, id_src1)
                | (id_two_src & match(mem_q.valid, mem_q.wb, mem_q.dest, id_src2));
        raw = FORWARD_EN ? (exe_q.load & exe_hit) : (exe_hit | mem_hit);
        hazard_detected = id_valid & ~flush & ~rst & raw;
        exe_d = (id_valid & ~flush & ~hazard_detected) ? {1'b1, id_wb_en, id_mem_r_en, id_dest} : '0;
        mem_d = {exe_q.valid, exe_q.wb, exe_q.dest};
        cnt_d = (hazard_detected & ~&cnt_q) ? cnt_q + STALL_CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q <= '0;
            mem_q <= '0;
            cnt_q <= '0;
        end else if (!freeze) begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: drives a forwarding DUT (4-bit counter) and a non-forwarding DUT
// from shared ID stimulus; expected values come from an issue-age model via a scoreboard queue.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_two_src, id_wb_en, id_mem_r_en, flush, freeze;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       hz_f, hz_n;
    logic [3:0] cnt_f;
    logic [15:0] cnt_n;

    hazard_scoreboard #(.REG_ADDR_LEN(5), .FORWARD_EN(1'b1), .STALL_CNT_W(4)) dut_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
        .hazard_detected(hz_f), .stall_count(cnt_f)
    );

    hazard_scoreboard #(.REG_ADDR_LEN(5), .FORWARD_EN(1'b0), .STALL_CNT_W(16)) dut_n (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
        .hazard_detected(hz_n), .stall_count(cnt_n)
    );

    // Accepted instructions with the pipeline-advance tick at which they entered EXE.
    typedef struct {
        int d;
        int t;
        bit wb;
        bit ld;
        int dest;
    } ins_t;

    typedef struct {
        bit hz0;
        bit hz1;
        int c0;
        int c1;
        bit cc;
    } exp_t;

    ins_t inflight[$];
    exp_t sbq[$];
    int   pt[2];
    int   cnt[2];
    int   cmax[2];
    bit   known;
    int   checks, passes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        else passes++;
    endtask

    // Age 1 = in EXE, age 2 = in MEM; forwarding only leaves the load-use case.
    function automatic bit model_hz(input int d, input bit r, input bit v, input bit fl,
                                    input bit two, input int s1, input int s2);
        if (r || !v || fl) return 1'b0;
        foreach (inflight[i]) begin
            int age;
            age = pt[d] - inflight[i].t;
            if (inflight[i].d == d && inflight[i].wb && inflight[i].dest != 0 &&
                (inflight[i].dest == s1 || (two && inflight[i].dest == s2)) &&
                (d == 0 ? (age == 1 && inflight[i].ld) : (age == 1 || age == 2)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic cycle(input bit r, input bit v, input int s1, input int s2, input bit two,
                         input int d, input bit wb, input bit ld, input bit fl, input bit fz);
        bit   h[2];
        exp_t e;
        ins_t n;
        ins_t keep[$];
        @(negedge clk);
        rst = r; id_valid = v; id_src1 = 5'(s1); id_src2 = 5'(s2); id_two_src = two;
        id_dest = 5'(d); id_wb_en = wb; id_mem_r_en = ld; flush = fl; freeze = fz;
        for (int k = 0; k < 2; k++) h[k] = model_hz(k, r, v, fl, two, s1, s2);
        e.hz0 = h[0]; e.hz1 = h[1]; e.c0 = cnt[0]; e.c1 = cnt[1]; e.cc = known;
        sbq.push_back(e);
        for (int k = 0; k < 2; k++) begin
            if (r) cnt[k] = 0;
            else if (!fz) begin
                if (h[k] && cnt[k] < cmax[k]) cnt[k]++;
                if (v && !fl && !h[k]) begin
                    n.d = k; n.t = pt[k]; n.wb = wb; n.ld = ld; n.dest = d;
                    inflight.push_back(n);
                end
                pt[k]++;
            end
        end
        if (r) known = 1'b1;
        foreach (inflight[i])
            if (!r && pt[inflight[i].d] - inflight[i].t <= 2) keep.push_back(inflight[i]);
        inflight = keep;
    endtask

    task automatic ins(input int s1, input int s2, input bit two, input int d, input bit wb, input bit ld);
        cycle(0, 1, s1, s2, two, d, wb, ld, 0, 0);
    endtask

    task automatic nop();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset1();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cchk(input string name, input int ef, input int en);
        #4;
        check({name, "_cnt_fwd"}, 32'(cnt_f), ef);
        check({name, "_cnt_nofwd"}, 32'(cnt_n), en);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("hz_fwd", 32'(hz_f), 32'(e.hz0));
                check("hz_nofwd", 32'(hz_n), 32'(e.hz1));
                if (e.cc) begin
                    check("cnt_fwd", 32'(cnt_f), e.c0);
                    check("cnt_nofwd", 32'(cnt_n), e.c1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        id_dest = 0; id_wb_en = 0; id_mem_r_en = 0; flush = 0; freeze = 0;
        cmax[0] = 15; cmax[1] = 65535;
        reset1();
        ins(1, 0, 0, 3, 1, 1);
        for (int k = 0; k < 3; k++) cycle(1, 1, 3, 3, 1, 7, 1, 1, 0, k == 1);
        ins(3, 3, 1, 5, 1, 0);
        nop(); cchk("reset", 0, 0);
        reset1(); ins(1, 0, 0, 3, 1, 1); repeat (3) ins(3, 4, 1, 5, 1, 0);
        nop(); cchk("load_use", 1, 2);
        reset1(); ins(1, 2, 1, 3, 1, 0); repeat (3) ins(3, 4, 1, 5, 1, 0);
        nop(); cchk("alu_use", 0, 2);
        reset1(); ins(1, 0, 0, 2, 1, 0); repeat (3) ins(1, 2, 1, 6, 1, 0);
        nop(); cchk("raw_adj", 0, 2);
        reset1(); ins(1, 0, 0, 2, 1, 0); nop(); repeat (2) ins(1, 2, 1, 6, 1, 0);
        nop(); cchk("raw_gap", 0, 1);
        reset1(); ins(1, 0, 0, 0, 1, 0); repeat (3) ins(1, 0, 1, 6, 1, 0);
        nop(); cchk("r0", 0, 0);
        reset1(); ins(1, 0, 0, 3, 1, 1); repeat (2) ins(7, 3, 0, 4, 1, 0);
        nop(); cchk("one_src", 0, 0);
        reset1(); ins(1, 0, 0, 3, 1, 1); repeat (3) ins(7, 3, 1, 0, 0, 0);
        nop(); cchk("two_src", 1, 2);
        reset1(); ins(1, 0, 0, 3, 1, 1); cycle(0, 1, 3, 4, 1, 5, 1, 0, 1, 0);
        repeat (2) ins(3, 4, 1, 5, 1, 0);
        nop(); cchk("flush", 0, 1);
        reset1(); ins(1, 0, 0, 3, 1, 1); repeat (4) cycle(0, 1, 3, 4, 1, 5, 1, 0, 0, 1);
        repeat (3) ins(3, 4, 1, 5, 1, 0);
        nop(); cchk("freeze", 1, 2);
        ins(1, 0, 0, 3, 1, 1); cycle(1, 1, 3, 4, 1, 5, 1, 0, 0, 1); ins(3, 4, 1, 5, 1, 0);
        nop(); cchk("rst_freeze", 0, 0);
        reset1();
        repeat (20) begin
            ins(1, 0, 0, 3, 1, 1);
            repeat (2) ins(3, 4, 1, 5, 1, 0);
        end
        nop(); cchk("sat", 15, 40);
        reset1();
        repeat (3000)
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
        nop();
        @(negedge clk);
        #5;
        check("drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard source for the ID stage. Tracks the destination registers of instructions in flight in EXE and MEM, and compares them against the source registers of the instruction currently in ID. On a read-after-write conflict it drives `hazard_detected` to the decode controller, which then squashes that cycle's writes. It also records the bubble it has forced and keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- `REG_ADDR_LEN`, 5, width of register-file addresses.
- `FORWARD_EN`, 1, 1 = forwarding unit present (stall on load-use only); 0 = stall on any RAW against EXE or MEM.
- `STALL_CNT_W`, 16, width of the stall counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_src1`  in  REG_ADDR_LEN  first source register of ID instruction.
- `id_src2`  in  REG_ADDR_LEN  second source register of ID instruction.
- `id_two_src`  in  1  ID instruction reads `id_src2` (R-type, ST, BNE).
- `id_dest`  in  REG_ADDR_LEN  destination register of ID instruction.
- `id_wb_en`  in  1  ID instruction writes the register file (controller WB_EN, pre-squash).
- `id_mem_r_en`  in  1  ID instruction is a load.
- `flush`  in  1  taken branch; the ID instruction is discarded this cycle.
- `freeze`  in  1  global pipeline hold (memory wait); all state holds.
- `hazard_detected`  out  1  combinational stall request to the controller and the IF/ID register.
- `stall_count`  out  STALL_CNT_W  registered count of stall cycles.

## Operation
- Two slot registers, EXE and MEM, each holding {valid, wb, load, dest}.
- match(slot, r) = slot.valid & slot.wb & (slot.dest == r) & (r != 0). Register 0 never creates a hazard.
- src_hit(slot) = match(slot, id_src1) | (id_two_src & match(slot, id_src2)).
- FORWARD_EN=0: raw = src_hit(EXE) | src_hit(MEM).
- FORWARD_EN=1: raw = EXE.load & src_hit(EXE).
- hazard_detected = id_valid & !flush & !rst & raw.
- hazard_detected must not depend on `id_wb_en`, `id_mem_r_en` or `id_dest`. This avoids a combinational loop through the controller, which zeroes WB_EN under hazard.
- Slot update on each edge with !rst & !freeze:
  - MEM <= EXE.
  - If id_valid & !flush & !hazard_detected: EXE <= {1, id_wb_en, id_mem_r_en, id_dest}.
  - Otherwise EXE <= bubble (all fields 0).
- freeze=1: EXE, MEM and stall_count hold. hazard_detected is still evaluated from the held state.
- stall_count: +1 on each edge with !freeze & hazard_detected. Saturates at all-ones and never wraps.
- flush and a would-be hazard in the same cycle: flush wins. hazard_detected=0, EXE receives a bubble, no count.

## Timing
- Reset: EXE and MEM slots all-zero, stall_count=0, hazard_detected=0 while rst is high and on the first cycle after reset.
- rst asserted mid-operation clears all state on that edge, regardless of freeze.
- hazard_detected has zero-cycle latency: it is combinational from the ID inputs and registered slots within the same cycle.
- Load-use, FORWARD_EN=1: LD r1 in ID at cycle 0, ADD using r1 in ID at cycle 1.
  - Cycle 1: hazard_detected=1.
  - Cycle 2: EXE=bubble, MEM=LD, hazard_detected=0.
  - Exactly 1 stall.
- RAW, FORWARD_EN=0: dependent instruction directly follows the producer.
  - Stall cycles 1 and 2, released in cycle 3: 2 stalls.
  - Separated by one independent instruction: 1 stall.
- A producer in WB does not stall; the register file resolves same-cycle write/read.
- stall_count updates one edge after the stalled cycle.

## Test plan
- **Reset:** hold rst for 3 cycles with id_valid=1 and srcs matching garbage. Required: hazard_detected=0 throughout, and stall_count=0 after release.
- **Load-use, FORWARD_EN=1:** LD r3 then ADD r5=r3+r4. Required: hazard_detected=1 for exactly one cycle, EXE holds a bubble the next cycle, stall_count=1. Replace LD with ADD r3: no stall.
- **RAW, FORWARD_EN=0:** ADDI r2, then SUB r6=r1-r2. Required: 2 stall cycles, stall_count=2. Insert one NOP between them: 1 stall. A dependence on r0 with r0 as destination: 0 stalls.
- **id_two_src gating:** ADDI r4=r7+imm with id_src2=r3 matching an EXE load, id_two_src=0. Required: no hazard. The same instruction with id_two_src=1 (ST): hazard.
- **Flush and freeze:** a load-use conflict coinciding with flush=1. Required: hazard_detected=0 and a bubble enters EXE. A stall held under freeze=1 for 4 cycles: slots and stall_count unchanged, hazard_detected stays 1, and 1 stall is counted after freeze drops.
- **Saturation:** STALL_CNT_W=4 with 20 consecutive stall cycles. Required: stall_count reaches 15 and holds at 15.
